sram_array: RTL and testbench

Parametrised word-organised storage array, the clocked multi-bit, multi-word successor to the single NAND-latch bitcell. It stores DEPTH words of WIDTH bits and accepts one read or write per cycle through a sel/r_w request port. It adds per-bit write masking, a one-cycle registered read with a tristate output bus, address range checking, and a hardware clear sequencer. It sits between a bus or test controller and the datapath as a small register file or scratch memory.

---
 rtl/sram_array_if.sv | 26 ++
 rtl/sram_array.sv | 87 ++++++++
 tb/tb_sram_array.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sram_array_if.sv
// Request/response bundle for sram_array: request fields from the controller,
// status and read-response handshake back from the array.
interface sram_array_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              sel;
    logic              r_w;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  in;
    logic [WIDTH-1:0]  wmask;
    logic              clear;
    logic              ready;
    logic              out_valid;
    logic              err;

    modport master (
        output sel, r_w, addr, in, wmask, clear,
        input  ready, out_valid, err
    );

    modport slave (
        input  sel, r_w, addr, in, wmask, clear,
        output ready, out_valid, err
    );
endinterface

// File: rtl/sram_array.sv
// Word-organised storage array with masked writes, registered tristate reads,
// address range checking and a word-at-a-time hardware clear sequencer.
module sram_array #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned ADDR_W         = 4,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    sram_array_if.slave      bus,
    output wire  [WIDTH-1:0] out
);
    localparam int unsigned       IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DepthW  = DEPTH[ADDR_W:0];
    localparam logic [IdxW-1:0]   LastIdx = IdxW'(DEPTH - 1);

    typedef enum logic {StClear, StIdle} state_t;

    state_t            state_q;
    logic [IdxW-1:0]   cnt_q;
    logic              out_valid_q;
    logic              err_q;
    logic [WIDTH-1:0]  rdata_q;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              ready;
    logic              accept;
    logic              in_range;
    logic [IdxW-1:0]   idx;

    assign ready    = (state_q == StIdle);
    // clear wins over a simultaneous request even though ready is high
    assign accept   = bus.sel & ready & ~bus.clear;
    assign in_range = ({1'b0, bus.addr} < DepthW);
    assign idx      = bus.addr[IdxW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR_ON_RESET ? StClear : StIdle;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            unique case (state_q)
                StClear: begin
                    if (cnt_q == LastIdx) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StIdle: begin
                    if (bus.clear) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                    end else if (accept) begin
                        err_q <= ~in_range;
                        if (!bus.r_w) begin
                            out_valid_q <= 1'b1;
                            rdata_q     <= in_range ? mem[idx] : '0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[cnt_q] <= '0;
        end else if (accept && bus.r_w && in_range) begin
            mem[idx] <= (mem[idx] & ~bus.wmask) | (bus.in & bus.wmask);
        end
    end

    assign bus.ready     = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;
    assign out           = out_valid_q ? rdata_q : {WIDTH{1'bz}};
endmodule

// File: tb/tb_sram_array.sv
// Randomised and directed bench for sram_array, checked every cycle against a
// behavioural model of the array contents and clear countdown.
module tb_sram_array;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 5;

    logic             clk;
    logic             rst_n;
    wire  [WIDTH-1:0] out;

    sram_array_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    sram_array #(
        .WIDTH         (WIDTH),
        .DEPTH         (DEPTH),
        .ADDR_W        (ADDR_W),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .out  (out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: contents array, remaining clear cycles, pending response
    logic [WIDTH-1:0] model_mem [DEPTH];
    int               m_clear_left = DEPTH;
    logic             m_valid = 1'b0;
    logic             m_err = 1'b0;
    logic [WIDTH-1:0] m_data = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clear_left = DEPTH;
            m_valid      = 1'b0;
            m_err        = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (m_clear_left > 0) begin
                model_mem[DEPTH - m_clear_left] = '0;
                m_clear_left--;
            end else if (bus.clear) begin
                m_clear_left = DEPTH;
            end else if (bus.sel) begin
                m_err = (int'(bus.addr) >= DEPTH);
                if (!bus.r_w) begin
                    m_valid = 1'b1;
                    m_data  = m_err ? '0 : model_mem[bus.addr[3:0]];
                end else if (!m_err) begin
                    model_mem[bus.addr[3:0]] = (model_mem[bus.addr[3:0]] & ~bus.wmask)
                                             | (bus.in & bus.wmask);
                end
            end
        end
    end

    always @(negedge clk) begin
        check("ready", 32'(bus.ready), 32'(m_clear_left == 0));
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("err", 32'(bus.err), 32'(m_err));
        if (m_valid) check("out", 32'(out), 32'(m_data));
    end

    task automatic idle_inputs();
        bus.sel = 1'b0; bus.r_w = 1'b0; bus.addr = '0;
        bus.in = '0; bus.wmask = '0; bus.clear = 1'b0;
    endtask

    task automatic step(input logic sel, input logic r_w, input logic [ADDR_W-1:0] addr,
                        input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] wm,
                        input logic clr);
        bus.sel = sel; bus.r_w = r_w; bus.addr = addr;
        bus.in = din; bus.wmask = wm; bus.clear = clr;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic count_not_ready(input string name);
        int n = 0;
        while (!bus.ready && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        check(name, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(bus.ready), 32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        count_not_ready("clear_after_reset_len");

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, ADDR_W'(i), '0, '0, 1'b0);
            check("cleared_read", {23'd0, bus.out_valid, out}, 32'h100);
        end
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);
        check("valid_drops", 32'(bus.out_valid), 32'd0);

        step(1'b1, 1'b1, 5'd3, 8'hA5, 8'hFF, 1'b0);
        step(1'b1, 1'b1, 5'd3, 8'hFF, 8'h0F, 1'b0);
        step(1'b1, 1'b0, 5'd3, '0, '0, 1'b0);
        check("masked_write", {22'd0, bus.err, bus.out_valid, out}, 32'h1AF);

        step(1'b1, 1'b1, 5'd7, 8'h3C, 8'hFF, 1'b0);
        step(1'b1, 1'b0, 5'd7, '0, '0, 1'b0);
        check("b2b_read7", {23'd0, bus.out_valid, out}, 32'h13C);
        step(1'b1, 1'b0, 5'd8, '0, '0, 1'b0);
        check("b2b_read8", {23'd0, bus.out_valid, out}, 32'h100);

        step(1'b1, 1'b1, 5'd20, 8'h55, 8'hFF, 1'b0);
        check("oor_write", {30'd0, bus.err, bus.out_valid}, 32'h2);
        step(1'b1, 1'b0, 5'd20, '0, '0, 1'b0);
        check("oor_read", {22'd0, bus.err, bus.out_valid, out}, 32'h300);

        step(1'b1, 1'b1, 5'd3, 8'hEE, 8'hFF, 1'b1);
        check("clear_priority_ov", 32'(bus.out_valid | bus.err), 32'd0);
        count_not_ready("clear_cmd_len");
        step(1'b1, 1'b0, 5'd3, '0, '0, 1'b0);
        check("after_clear3", {23'd0, bus.out_valid, out}, 32'h100);
        step(1'b1, 1'b0, 5'd7, '0, '0, 1'b0);
        check("after_clear7", {23'd0, bus.out_valid, out}, 32'h100);

        for (int c = 0; c < 800; c++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ADDR_W'($urandom_range(0, 31)), WIDTH'($urandom), WIDTH'($urandom),
                 1'($urandom_range(0, 59) == 0));
        end
        while (!bus.ready) step(1'b0, 1'b0, '0, '0, '0, 1'b0);

        step(1'b1, 1'b0, 5'd2, '0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("reset_mid_read", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_not_ready("clear_after_read_reset");

        step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        repeat (4) step(1'b0, 1'b0, '0, '0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("reset_mid_clear", {30'd0, bus.ready, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_not_ready("clear_restart_len");
        for (int i = 0; i < DEPTH; i += 5) begin
            step(1'b1, 1'b0, ADDR_W'(i), '0, '0, 1'b0);
            check("final_read", {23'd0, bus.out_valid, out}, 32'h100);
        end
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
